// File: rtl/qiangda_pkg.sv
// Shared definitions for the quiz host controller: FSM state codes,
// contestant ID constants, the 2-digit BCD type and small BCD helpers.
package qiangda_pkg;

    localparam int unsigned BCD_W   = 8;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned NUM_ID  = 4;
    localparam int unsigned PTS_W   = 4;

    typedef logic [BCD_W-1:0] bcd2_t;
    typedef logic [ID_W-1:0]  cid_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ANSWER = 3'd2,
        ST_NOBODY = 3'd3,
        ST_SHOW   = 3'd4
    } state_e;

    localparam cid_t  ID_NONE  = 3'd0;
    localparam cid_t  ID_MIN   = 3'd1;
    localparam cid_t  ID_MAX   = 3'd4;
    localparam bcd2_t BCD_ZERO = 8'h00;
    localparam bcd2_t BCD_MAX  = 8'h99;

    // A contestant ID is meaningful only in 1..4.
    function automatic logic id_valid(input cid_t id);
        return (id >= ID_MIN) && (id <= ID_MAX);
    endfunction

    // 2-digit BCD to binary (0..99 for well-formed input).
    function automatic logic [7:0] bcd2_to_bin(input bcd2_t b);
        return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
    endfunction

    // Binary 0..99 to 2-digit BCD.
    function automatic bcd2_t bin_to_bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // BCD decrement that holds at 00.
    function automatic bcd2_t bcd2_dec(input bcd2_t b);
        if (b == BCD_ZERO)
            return BCD_ZERO;
        if (b[3:0] == 4'd0)
            return {b[7:4] - 4'd1, 4'd9};
        return {b[7:4], b[3:0] - 4'd1};
    endfunction

    // BCD increment that wraps 99 -> 00.
    function automatic bcd2_t bcd2_inc_wrap(input bcd2_t b);
        if (b == BCD_MAX)
            return BCD_ZERO;
        if (b[3:0] >= 4'd9)
            return {b[7:4] + 4'd1, 4'd0};
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/qiangda_host_bcd2_addsub.sv
// bcd2_addsub: combinational 2-digit BCD add/subtract of a 1-digit operand,
// saturating at 00 and 99.
//   i_a   : 2-digit BCD operand
//   i_b   : binary 1-digit operand (0..9)
//   i_sub : 1 = subtract, 0 = add
//   o_y   : saturated 2-digit BCD result
module bcd2_addsub
    import qiangda_pkg::*;
(
    input  logic [BCD_W-1:0] i_a,
    input  logic [PTS_W-1:0] i_b,
    input  logic             i_sub,
    output logic [BCD_W-1:0] o_y
);

    logic [8:0] w_a_bin;
    logic [8:0] w_b_bin;
    logic [8:0] w_res;

    // Work in binary, clamp to 0..99, convert back.
    always_comb begin
        w_a_bin = 9'(bcd2_to_bin(i_a));
        w_b_bin = 9'(i_b);
        w_res   = 9'd0;
        if (i_sub)
            w_res = (w_a_bin > w_b_bin) ? (w_a_bin - w_b_bin) : 9'd0;
        else
            w_res = w_a_bin + w_b_bin;
        if (w_res > 9'd99)
            w_res = 9'd99;
    end

    assign o_y = bin_to_bcd2(7'(w_res));

endmodule

// File: rtl/qiangda_host.sv
// qiangda_host: judge-side controller for the 4-contestant quiz buzzer.
// Holds/arms the buzzer via clr_n, latches the winner, times the answer
// window, applies verdicts and fouls to saturating BCD scores and counts
// completed rounds.
//   clk1hz, reset      : 1 Hz tick clock, async active-high reset
//   start              : host arms a round
//   win_valid/win_id   : buzzer winner report
//   foul_valid/foul_id : early press while buzzer held
//   time_up            : buzzer grab window expired
//   judge_ok/judge_bad : host verdict
//   clr_n              : buzzer clear (0 hold, 1 armed)
//   state              : FSM state code
//   cur_id             : answering contestant, 0 = none
//   ans_bcd            : remaining answer time (BCD)
//   score_bcd          : four BCD scores, [7:0] = contestant 1
//   round_bcd          : completed rounds (BCD, wraps)
module qiangda_host
    import qiangda_pkg::*;
#(
    parameter int unsigned INIT_SCORE = 10,
    parameter int unsigned POINTS_OK  = 2,
    parameter int unsigned POINTS_BAD = 1,
    parameter int unsigned ANS_TIME   = 20,
    parameter int unsigned SHOW_TIME  = 3
)(
    input  logic                    clk1hz,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    win_valid,
    input  logic [ID_W-1:0]         win_id,
    input  logic                    foul_valid,
    input  logic [ID_W-1:0]         foul_id,
    input  logic                    time_up,
    input  logic                    judge_ok,
    input  logic                    judge_bad,
    output logic                    clr_n,
    output logic [STATE_W-1:0]      state,
    output logic [ID_W-1:0]         cur_id,
    output logic [BCD_W-1:0]        ans_bcd,
    output logic [NUM_ID*BCD_W-1:0] score_bcd,
    output logic [BCD_W-1:0]        round_bcd
);

    localparam bcd2_t             INIT_BCD = bin_to_bcd2(7'(INIT_SCORE));
    localparam bcd2_t             ANS_BCD  = bin_to_bcd2(7'(ANS_TIME));
    localparam logic [HOLD_W-1:0] SHOW_LD  = HOLD_W'(SHOW_TIME);
    localparam logic [PTS_W-1:0]  OK_PTS   = PTS_W'(POINTS_OK);
    localparam logic [PTS_W-1:0]  BAD_PTS  = PTS_W'(POINTS_BAD);

    state_e                         r_state;
    logic                           r_clr_n;
    cid_t                           r_cur_id;
    bcd2_t                          r_ans;
    bcd2_t                          r_round;
    logic [HOLD_W-1:0]              r_hold;
    logic                           r_foul_q;
    logic [NUM_ID-1:0][BCD_W-1:0]   r_score;

    logic                           w_foul_edge;
    logic                           w_verdict;
    logic                           w_upd;
    logic                           w_sub;
    cid_t                           w_sel_id;
    logic [1:0]                     w_sel_idx;
    bcd2_t                          w_sel_score;
    bcd2_t                          w_new_score;

    // Pick which contestant's score changes this cycle and in which direction.
    always_comb begin
        w_foul_edge = foul_valid & ~r_foul_q & id_valid(foul_id);
        w_verdict   = judge_ok | judge_bad | (r_ans == BCD_ZERO);
        w_upd       = 1'b0;
        w_sub       = 1'b0;
        w_sel_id    = r_cur_id;
        case (r_state)
            ST_IDLE: begin
                if (w_foul_edge) begin
                    w_upd    = 1'b1;
                    w_sub    = 1'b1;
                    w_sel_id = foul_id;
                end
            end
            ST_ANSWER: begin
                // judge_ok outranks judge_bad; timeout counts as wrong.
                if (judge_ok) begin
                    w_upd = id_valid(r_cur_id);
                end else if (w_verdict) begin
                    w_upd = id_valid(r_cur_id);
                    w_sub = 1'b1;
                end
            end
            default: begin
                w_upd = 1'b0;
            end
        endcase
        w_sel_idx   = 2'(w_sel_id - ID_MIN);
        w_sel_score = r_score[w_sel_idx];
    end

    bcd2_addsub u_addsub (
        .i_a   (w_sel_score),
        .i_b   (w_sub ? BAD_PTS : OK_PTS),
        .i_sub (w_sub),
        .o_y   (w_new_score)
    );

    // Round FSM with registered outputs.
    always_ff @(posedge clk1hz or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_clr_n  <= 1'b0;
            r_cur_id <= ID_NONE;
            r_ans    <= BCD_ZERO;
            r_round  <= BCD_ZERO;
            r_hold   <= '0;
            r_foul_q <= 1'b0;
            r_score  <= {NUM_ID{INIT_BCD}};
        end else begin
            r_foul_q <= foul_valid;
            if (w_upd)
                r_score[w_sel_idx] <= w_new_score;

            case (r_state)
                ST_IDLE: begin
                    r_clr_n <= 1'b0;
                    if (start) begin
                        r_state <= ST_ARMED;
                        r_clr_n <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A valid winner beats a simultaneous time_up.
                    if (win_valid && id_valid(win_id)) begin
                        r_cur_id <= win_id;
                        r_ans    <= ANS_BCD;
                        r_state  <= ST_ANSWER;
                    end else if (time_up) begin
                        r_state <= ST_NOBODY;
                        r_clr_n <= 1'b0;
                    end
                end
                ST_ANSWER: begin
                    if (w_verdict) begin
                        r_hold  <= SHOW_LD;
                        r_state <= ST_SHOW;
                        r_clr_n <= 1'b0;
                    end else begin
                        r_ans <= bcd2_dec(r_ans);
                    end
                end
                ST_NOBODY: begin
                    r_hold  <= SHOW_LD;
                    r_state <= ST_SHOW;
                    r_clr_n <= 1'b0;
                end
                ST_SHOW: begin
                    // Counter reaching zero ends the round, so SHOW lasts SHOW_TIME cycles.
                    if (r_hold < HOLD_W'(2)) begin
                        r_hold   <= '0;
                        r_round  <= bcd2_inc_wrap(r_round);
                        r_cur_id <= ID_NONE;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_clr_n  <= 1'b0;
                    r_cur_id <= ID_NONE;
                end
            endcase
        end
    end

    assign clr_n     = r_clr_n;
    assign state     = r_state;
    assign cur_id    = r_cur_id;
    assign ans_bcd   = r_ans;
    assign score_bcd = r_score;
    assign round_bcd = r_round;

endmodule

// File: tb/tb_qiangda_host.sv
// Testbench for qiangda_host: directed round scenarios plus random stimulus,
// with expected outputs from an integer-level model queued per clock and
// compared by an independent monitor on the falling edge.
module tb_qiangda_host;

    localparam int unsigned P_INIT = 10;
    localparam int unsigned P_OK   = 2;
    localparam int unsigned P_BAD  = 1;
    localparam int unsigned P_ANS  = 20;
    localparam int unsigned P_SHOW = 3;

    logic        clk1hz = 1'b0;
    logic        reset;
    logic        start;
    logic        win_valid;
    logic [2:0]  win_id;
    logic        foul_valid;
    logic [2:0]  foul_id;
    logic        time_up;
    logic        judge_ok;
    logic        judge_bad;
    logic        clr_n;
    logic [2:0]  state;
    logic [2:0]  cur_id;
    logic [7:0]  ans_bcd;
    logic [31:0] score_bcd;
    logic [7:0]  round_bcd;

    int n_vec = 0;
    int n_err = 0;

    logic [54:0] exp_q[$];

    // Reference model: phase 0 idle, 1 armed, 2 answering, 3 nobody, 4 showing.
    int m_ph;
    int m_clr;
    int m_cur;
    int m_ans;
    int m_shown;
    int m_round;
    int m_fprev;
    int m_sc[1:4];

    qiangda_host #(
        .INIT_SCORE (P_INIT),
        .POINTS_OK  (P_OK),
        .POINTS_BAD (P_BAD),
        .ANS_TIME   (P_ANS),
        .SHOW_TIME  (P_SHOW)
    ) dut (
        .clk1hz     (clk1hz),
        .reset      (reset),
        .start      (start),
        .win_valid  (win_valid),
        .win_id     (win_id),
        .foul_valid (foul_valid),
        .foul_id    (foul_id),
        .time_up    (time_up),
        .judge_ok   (judge_ok),
        .judge_bad  (judge_bad),
        .clr_n      (clr_n),
        .state      (state),
        .cur_id     (cur_id),
        .ans_bcd    (ans_bcd),
        .score_bcd  (score_bcd),
        .round_bcd  (round_bcd)
    );

    always #5 clk1hz = ~clk1hz;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [54:0] model_vec();
        return {3'(m_ph), 1'(m_clr), 3'(m_cur), to_bcd(m_ans),
                to_bcd(m_sc[4]), to_bcd(m_sc[3]), to_bcd(m_sc[2]), to_bcd(m_sc[1]),
                to_bcd(m_round)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_clr = 0; m_cur = 0; m_ans = 0; m_shown = 0;
        m_round = 0; m_fprev = 0;
        for (int i = 1; i <= 4; i++) m_sc[i] = int'(P_INIT);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int fid;
        int wid;
        if (reset) begin
            model_reset();
            return;
        end
        fid = int'(foul_id);
        wid = int'(win_id);
        case (m_ph)
            0: begin
                if (foul_valid && m_fprev == 0 && fid >= 1 && fid <= 4)
                    m_sc[fid] = (m_sc[fid] > int'(P_BAD)) ? m_sc[fid] - int'(P_BAD) : 0;
                if (start) m_ph = 1;
            end
            1: begin
                if (win_valid && wid >= 1 && wid <= 4) begin
                    m_cur = wid; m_ans = int'(P_ANS); m_ph = 2;
                end else if (time_up) begin
                    m_ph = 3;
                end
            end
            2: begin
                if (judge_ok) begin
                    m_sc[m_cur] = (m_sc[m_cur] + int'(P_OK) > 99) ? 99 : m_sc[m_cur] + int'(P_OK);
                    m_ph = 4; m_shown = 0;
                end else if (judge_bad || m_ans == 0) begin
                    m_sc[m_cur] = (m_sc[m_cur] > int'(P_BAD)) ? m_sc[m_cur] - int'(P_BAD) : 0;
                    m_ph = 4; m_shown = 0;
                end else begin
                    m_ans = m_ans - 1;
                end
            end
            3: begin
                m_ph = 4; m_shown = 0;
            end
            default: begin
                m_shown = m_shown + 1;
                if (m_shown >= int'(P_SHOW)) begin
                    m_round = (m_round + 1) % 100;
                    m_cur = 0;
                    m_ph = 0;
                end
            end
        endcase
        m_clr = (m_ph == 1 || m_ph == 2) ? 1 : 0;
        m_fprev = foul_valid ? 1 : 0;
    endtask

    function automatic void check(input string tag, input logic [54:0] exp);
        logic [54:0] act = {state, clr_n, cur_id, ans_bcd, score_bcd, round_bcd};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got st=%0d clr=%0b id=%0d ans=%h sc=%h rnd=%h want st=%0d clr=%0b id=%0d ans=%h sc=%h rnd=%h",
                     tag, $time, state, clr_n, cur_id, ans_bcd, score_bcd, round_bcd,
                     exp[54:52], exp[51], exp[50:48], exp[47:40], exp[39:8], exp[7:0]);
        end
    endfunction

    // Monitor: one queued expectation per clock edge, checked mid-cycle.
    always @(negedge clk1hz) begin
        if (exp_q.size() > 0)
            check("cycle", exp_q.pop_front());
    end

    task automatic clear_in();
        start = 1'b0; win_valid = 1'b0; win_id = 3'd0; foul_valid = 1'b0;
        foul_id = 3'd0; time_up = 1'b0; judge_ok = 1'b0; judge_bad = 1'b0;
    endtask

    task automatic tick();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk1hz);
        #1;
    endtask

    task automatic idle(input int n);
        clear_in();
        repeat (n) tick();
    endtask

    task automatic play_round(input logic [2:0] id, input logic ok, input logic bad);
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = id; tick(); clear_in();
        judge_ok = ok; judge_bad = bad; tick(); clear_in();
        idle(int'(P_SHOW) + 1);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        clear_in();
        tick(); tick();
        reset = 1'b0;

        // Win by 3, verdict in the second answer cycle.
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = 3'd3; tick(); clear_in();
        tick();
        judge_ok = 1'b1; tick(); clear_in();
        idle(4);

        // Win by 2, let the answer window run out.
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = 3'd2; tick(); clear_in();
        idle(int'(P_ANS) + 6);

        // Foul held high for five cycles: one deduction only.
        foul_valid = 1'b1; foul_id = 3'd4;
        repeat (5) tick();
        idle(1);

        // Drive contestant 1 to 00, then a wrong verdict must hold at 00.
        repeat (int'(P_INIT) + 2) begin
            foul_valid = 1'b1; foul_id = 3'd1; tick();
            foul_valid = 1'b0; tick();
        end
        play_round(3'd1, 1'b0, 1'b1);

        // Contestant 2 from 09 to 08, then up to 98 and into saturation.
        foul_valid = 1'b1; foul_id = 3'd2; tick(); idle(1);
        repeat (47) play_round(3'd2, 1'b1, 1'b0);

        // Win and time_up together; then both verdicts together.
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = 3'd1; time_up = 1'b1; tick(); clear_in();
        judge_ok = 1'b1; judge_bad = 1'b1; tick(); clear_in();
        idle(4);

        // Invalid winner IDs are ignored; time_up then gives NOBODY.
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = 3'd6; tick();
        win_id = 3'd0; tick(); clear_in();
        time_up = 1'b1; tick(); clear_in();
        idle(5);

        // Asynchronous reset in the middle of an answer.
        start = 1'b1; tick(); clear_in();
        win_valid = 1'b1; win_id = 3'd4; tick(); clear_in();
        tick(); tick();
        @(negedge clk1hz);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset", model_vec());
        tick(); tick();
        reset = 1'b0;
        idle(1);

        // Random traffic.
        repeat (400) begin
            start      = ($urandom_range(0, 3) == 0);
            win_valid  = ($urandom_range(0, 2) == 0);
            win_id     = 3'($urandom_range(0, 7));
            foul_valid = 1'($urandom_range(0, 1));
            foul_id    = 3'($urandom_range(0, 7));
            time_up    = ($urandom_range(0, 7) == 0);
            judge_ok   = ($urandom_range(0, 9) == 0);
            judge_bad  = ($urandom_range(0, 9) == 0);
            tick();
        end
        clear_in();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk1hz);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qiangda_host.md
Name: qiangda_host

Overview:
- Judge/host-side controller for the 4-contestant quiz buzzer; the opposite end of the buzzer's clr/winner interface.
- Drives the buzzer's active-low clear, arms each round and consumes the winner ID, time-up and early-press (foul) reports.
- Times the answer window, applies the host's correct/wrong verdict to per-contestant 2-digit BCD scores, and counts rounds.
- Runs on the 1 Hz tick domain; outputs feed the scan/7-segment display mux.

Parameters:
- INIT_SCORE, 10, starting score per contestant (decimal, 0..99).
- POINTS_OK, 2, points added on correct verdict (1..9).
- POINTS_BAD, 1, points deducted on wrong verdict, answer timeout or foul (1..9).
- ANS_TIME, 20, answer window in clk1hz cycles (1..99).
- SHOW_TIME, 3, result hold in cycles before returning to IDLE (1..15).

Ports:
- clk1hz, in, 1, 1 Hz tick clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, host arms a round (level, sampled).
- win_valid, in, 1, buzzer reports a winner.
- win_id, in, 3, winner 1..4.
- foul_valid, in, 1, early press while clr_n=0.
- foul_id, in, 3, fouling contestant 1..4.
- time_up, in, 1, buzzer's grab window expired.
- judge_ok, in, 1, host verdict: correct.
- judge_bad, in, 1, host verdict: wrong.
- clr_n, out, 1, buzzer clear; 0 holds the buzzer, 1 arms it.
- state, out, 3, FSM state code.
- cur_id, out, 3, current answering contestant; 0 = none.
- ans_bcd, out, 8, remaining answer time, 2-digit BCD.
- score_bcd, out, 32, four 2-digit BCD scores; [7:0] = contestant 1 … [31:24] = contestant 4.
- round_bcd, out, 8, completed-round count, 2-digit BCD.

Behaviour:
- Reset: clr_n=0, state=IDLE, cur_id=0, ans_bcd=00, all scores=INIT_SCORE in BCD, round_bcd=00, foul edge register=0.
- Reset mid-operation aborts immediately to these values; a pending verdict is discarded.
- All transitions occur on posedge clk1hz; inputs are sampled, and registered outputs update one cycle after the cause.

FSM states:
- IDLE (0): clr_n=0.
  - Rising edge of foul_valid (sampled 0→1) with foul_id in 1..4: deduct POINTS_BAD from that score; one deduction per edge, and held-high foul_valid does not repeat.
  - start=1 → ARMED. A foul edge and start in the same cycle: apply the deduction and transition.
- ARMED (1): clr_n=1.
  - win_valid=1 with win_id in 1..4: latch cur_id=win_id, load ans_bcd=ANS_TIME, go to ANSWER.
  - win_valid with win_id of 0 or 5..7 is ignored.
  - time_up=1 with no valid winner → NOBODY. Valid win and time_up together: win wins.
  - foul_valid is ignored here.
- ANSWER (2): clr_n=1.
  - Priority, highest first: judge_ok, then judge_bad, then timeout.
  - judge_ok: add POINTS_OK to the score of cur_id, saturating at 99.
  - judge_bad: subtract POINTS_BAD, saturating at 00.
  - Timeout is ans_bcd==00 at a clock edge with no verdict: same as judge_bad.
  - Otherwise ans_bcd decrements in BCD (10→09).
  - On any verdict or timeout: load the hold counter with SHOW_TIME and go to SHOW.
- NOBODY (3): clr_n=0; no score change; load the hold counter and go to SHOW.
- SHOW (4): clr_n=0; cur_id and ans_bcd frozen; hold counter decrements.
  - When the counter reaches 0: round_bcd += 1 (99 wraps to 00), cur_id=0, go to IDLE.
- Unused state codes recover to IDLE.
- Score update takes effect in the cycle following the verdict sample.
- Score arithmetic is 2-digit BCD with saturation; scores are never negative and never exceed 99.

Decomposition:
- Shared package qiangda_pkg:
  - state encodings IDLE/ARMED/ANSWER/NOBODY/SHOW;
  - contestant ID constants (ID_NONE=0, ID_MIN=1, ID_MAX=4);
  - BCD 8-bit type/width constant.
- One sub-module, bcd2_addsub: combinational 2-digit BCD add/subtract of a 1-digit operand, with 00/99 saturation. Instantiate it once, muxed onto the selected contestant.

Test Plan:
- Reset, start, win_id=3, judge_ok in the 2nd answer cycle → score_bcd[23:16] 10→12, SHOW for 3 cycles, round_bcd=01, clr_n back to 0.
- Win_id=2, no verdict → ans_bcd counts 20→00; the next cycle deducts, score_bcd[15:8]=09, then state=SHOW.
- foul_valid held high for 5 cycles in IDLE with foul_id=4 → exactly one deduction, score_bcd[31:24]=09.
- Score at 00 with judge_bad → stays 00; score at 98 with judge_ok → saturates at 99.
- ARMED with win_valid and time_up in the same cycle → ANSWER, cur_id latched; win_id=6 alone → remains ARMED.
- judge_ok and judge_bad together → +2 applied; reset asserted during ANSWER → all outputs at reset values immediately (async).
